control_pipe: RTL and testbench
===============================

# control_pipe

Pipelined main-control unit for the 5-stage RV32I core; successor to the single-cycle combinational opcode decoder. Decodes the opcode of the instruction in ID and carries the resulting control bundle through ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards, inserts bubbles, and squashes the ID instruction on a taken branch or jump. It sits between the IF/ID register and the datapath stage muxes.

## Interface

**Parameters**
- `ALUOP_W`, default 2: ALU-op field width.
- `RA_W`, default 5: register-address width.

**Ports** (clock and reset first)
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `id_valid` input 1: the IF/ID register holds a real instruction.
- `id_instr` input 32: instruction in ID.
- `ex_taken` input 1: the EX-stage branch/jump resolved as taken.
- `stall_ext` input 1: memory stall; freezes the whole pipe.
- `stall_if` output 1: hold PC and IF/ID.
- `flush_if` output 1: replace IF/ID with a bubble.
- `ex_valid`, `ex_branch`, `ex_jump`, `ex_alusrc`, `ex_asel` output 1 each: EX controls. `asel` = 1 selects PC as ALU operand A.
- `ex_aluop` output ALUOP_W: 00 add, 01 branch compare, 10 R-funct, 11 I-funct.
- `ex_rd` output RA_W: destination register in EX.
- `mem_valid`, `mem_read`, `mem_write` output 1 each.
- `mem_rd` output RA_W.
- `wb_valid`, `wb_regwrite` output 1 each.
- `wb_sel` output 2: 00 ALU, 01 memory, 10 PC+4, 11 immediate.
- `wb_rd` output RA_W.
- `id_illegal` output 1: the ID opcode is not decodable (combinational).

## Operation

**Decode** (combinational on `id_instr[6:0]`):
- R 0110011: `aluop` 10, `regwrite`.
- I-imm 0010011: `aluop` 11, `alusrc`, `regwrite`.
- Load 0000011: `aluop` 00, `alusrc`, `mem_read`, `regwrite`, `wb_sel` 01.
- Store 0100011: `aluop` 00, `alusrc`, `mem_write`.
- Branch 1100011: `aluop` 01, `branch`.
- JAL 1101111: `jump`, `regwrite`, `wb_sel` 10.
- Any other opcode: all-zero bundle, `id_illegal` = 1.
- Register use: rs1 and rs2 for R, S, B. rs1 only for I-imm and load. None for JAL.
- `rd` = `instr[11:7]`. `regwrite` is forced to 0 when rd = 0.

**Hazard logic**, evaluated in priority order:
1. `stall_ext`:
   - All stage registers hold.
   - `stall_if` = 1, `flush_if` = 0.
   - `ex_taken` is ignored this cycle. EX holds, so `ex_taken` is re-presented next cycle.
2. `ex_taken` with `ex_valid`:
   - A bubble is loaded into EX, squashing ID.
   - `flush_if` = 1, `stall_if` = 0.
   - EX→MEM→WB advance normally.
3. Load-use: `ex_valid` and EX-is-load and `ex_rd` ≠ 0 and `ex_rd` matches a used rs of the ID instruction.
   - A bubble is loaded into EX.
   - `stall_if` = 1.
4. Otherwise the decoded bundle advances, gated by `id_valid`. When `id_valid` = 0 a bubble enters EX.

**Bubbles and stage advance**
- A bubble has `valid` = 0 and all control bits 0, including `regwrite`, `mem_write` and `branch`.
- Each stage register copies the previous stage's fields unchanged; only the fields consumed downstream are kept.

## Timing

- **Latency:** an instruction decoded in ID at cycle n appears on `ex_*` at n+1, `mem_*` at n+2 and `wb_*` at n+3, absent stalls.
- **Combinational outputs:** `stall_if`, `flush_if` and `id_illegal` are combinational from the inputs and current stage registers, with no added latency.
- **Load-use stall:** exactly one cycle. The load reaches MEM and the comparison then fails.
- **Reset:**
  - Every registered output is 0 immediately on `rst_n` low, independent of `clk`.
  - While in reset, `stall_if` = 0 and `flush_if` = 0 (derived from zeroed registers).
  - Reset mid-stall discards all in-flight state.
  - The first edge after release loads normally.

## Configuration

- `CONTROL_PIPE_EXT_OPS_EN` defined: adds three opcodes.
  - LUI 0110111: `regwrite`, `wb_sel` 11, no rs.
  - AUIPC 0010111: `aluop` 00, `alusrc`, `asel`, `regwrite`, no rs.
  - JALR 1100111: `jump`, `alusrc`, `regwrite`, `wb_sel` 10, uses rs1.
- Undefined: these three opcodes decode as illegal bubbles, and `ex_asel` is tied to 0.

## Structure

- **Package `control_pkg`:**
  - opcode constants
  - ALU-op encodings
  - `wb_sel` encodings
  - packed ctrl bundle typedef
- **Sub-module `control_decode`:** the pure combinational opcode → bundle + rs-use decoder.
- `control_pipe` itself contains the stage registers and the hazard logic.

## Test plan

- **Reset:** assert `rst_n` = 0 mid-stream → all `ex_*`/`mem_*`/`wb_*` = 0 asynchronously; `stall_if` = `flush_if` = 0.
- **Load-use:** `lw x5` then `add x6,x5,x1` → `stall_if` = 1 for exactly 1 cycle; EX holds a bubble; the add reaches WB at cycle 5, one cycle late.
- **Taken branch:** `beq` taken (`ex_taken` = 1) with an R instruction in ID → `flush_if` = 1; R instruction never shows `wb_regwrite` = 1.
- **Simultaneous events:** `stall_ext` = 1 together with `ex_taken` and a load-use condition → registers unchanged, `flush_if` = 0; the flush occurs on the first cycle after `stall_ext` drops.
- **x0 destination:** `lw x0` followed by `add x1,x0,x0` → no stall; `wb_regwrite` = 0 for the lw.
- **Configuration:** LUI (0110111) → with macro, `wb_sel` = 11 and `wb_regwrite` = 1 at n+3; without macro, `id_illegal` = 1 and a bubble is inserted.

Source files
------------

// File: rtl/control_pkg.sv
// Shared definitions for the pipelined main-control unit: opcodes, ALU-op and
// write-back encodings, and the per-stage control bundles.
package control_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RFUNCT = 2'b10,
    ALU_IFUNCT = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wbsel_e;

  // Full bundle as produced by the decoder and held in ID/EX.
  typedef struct packed {
    logic   valid;
    logic   branch;
    logic   jump;
    logic   alusrc;
    logic   asel;
    aluop_e aluop;
    logic   mem_read;
    logic   mem_write;
    logic   regwrite;
    wbsel_e wb_sel;
  } ex_ctrl_t;

  typedef struct packed {
    logic   valid;
    logic   mem_read;
    logic   mem_write;
    logic   regwrite;
    wbsel_e wb_sel;
  } mem_ctrl_t;

  typedef struct packed {
    logic   valid;
    logic   regwrite;
    wbsel_e wb_sel;
  } wb_ctrl_t;

  function automatic mem_ctrl_t to_mem(input ex_ctrl_t c);
    mem_ctrl_t m;
    m.valid     = c.valid;
    m.mem_read  = c.mem_read;
    m.mem_write = c.mem_write;
    m.regwrite  = c.regwrite;
    m.wb_sel    = c.wb_sel;
    return m;
  endfunction

  function automatic wb_ctrl_t to_wb(input mem_ctrl_t c);
    wb_ctrl_t w;
    w.valid    = c.valid;
    w.regwrite = c.regwrite;
    w.wb_sel   = c.wb_sel;
    return w;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: control bundle, source-register use, illegal flag.
// CONTROL_PIPE_EXT_OPS_EN adds LUI, AUIPC and JALR; otherwise they decode as illegal.
module control_decode
  import control_pkg::*;
(
  input  logic [31:0] instr,
  output ex_ctrl_t    ctrl,
  output logic        use_rs1,
  output logic        use_rs2,
  output logic        illegal
);

  // Only the opcode and rd field steer decode; rs fields are compared in the pipe.
  logic unused_bits;
  assign unused_bits = ^instr[31:12];

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    ctrl    = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    illegal = 1'b0;

    case (instr[6:0])
      OP_R: begin
        ctrl.valid    = 1'b1;
        ctrl.aluop    = ALU_RFUNCT;
        ctrl.regwrite = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OP_IMM: begin
        ctrl.valid    = 1'b1;
        ctrl.aluop    = ALU_IFUNCT;
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        use_rs1       = 1'b1;
      end
      OP_LOAD: begin
        ctrl.valid    = 1'b1;
        ctrl.aluop    = ALU_ADD;
        ctrl.alusrc   = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.wb_sel   = WB_MEM;
        use_rs1       = 1'b1;
      end
      OP_STORE: begin
        ctrl.valid     = 1'b1;
        ctrl.aluop     = ALU_ADD;
        ctrl.alusrc    = 1'b1;
        ctrl.mem_write = 1'b1;
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.valid  = 1'b1;
        ctrl.aluop  = ALU_BRANCH;
        ctrl.branch = 1'b1;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
      end
      OP_JAL: begin
        ctrl.valid    = 1'b1;
        ctrl.jump     = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.wb_sel   = WB_PC4;
      end
`ifdef CONTROL_PIPE_EXT_OPS_EN
      OP_LUI: begin
        ctrl.valid    = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.wb_sel   = WB_IMM;
      end
      OP_AUIPC: begin
        ctrl.valid    = 1'b1;
        ctrl.aluop    = ALU_ADD;
        ctrl.alusrc   = 1'b1;
        ctrl.asel     = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_JALR: begin
        ctrl.valid    = 1'b1;
        ctrl.jump     = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.wb_sel   = WB_PC4;
        use_rs1       = 1'b1;
      end
`endif
      default: illegal = 1'b1;
    endcase

    // Writes to x0 are architecturally discarded; drop them here so hazard
    // and forwarding logic downstream never sees a phantom writer.
    if (instr[11:7] == 5'd0) ctrl.regwrite = 1'b0;
  end

endmodule

// File: rtl/control_pipe.sv
// Pipelined main control: decodes ID, carries control through ID/EX, EX/MEM, MEM/WB,
// and handles load-use stalls, taken-branch squash and external stalls.
// CONTROL_PIPE_EXT_OPS_EN (decoder) enables LUI/AUIPC/JALR; default build leaves ex_asel at 0.
module control_pipe
  import control_pkg::*;
#(
  parameter int ALUOP_W = 2,
  parameter int RA_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [31:0]        id_instr,
  input  logic               ex_taken,
  input  logic               stall_ext,
  output logic               stall_if,
  output logic               flush_if,
  output logic               ex_valid,
  output logic               ex_branch,
  output logic               ex_jump,
  output logic               ex_alusrc,
  output logic               ex_asel,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic [RA_W-1:0]    ex_rd,
  output logic               mem_valid,
  output logic               mem_read,
  output logic               mem_write,
  output logic [RA_W-1:0]    mem_rd,
  output logic               wb_valid,
  output logic               wb_regwrite,
  output logic [1:0]         wb_sel,
  output logic [RA_W-1:0]    wb_rd,
  output logic               id_illegal
);

  ex_ctrl_t        dec_ctrl;
  logic            use_rs1;
  logic            use_rs2;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic [RA_W-1:0] id_rd;

  control_decode u_decode (
    .instr   (id_instr),
    .ctrl    (dec_ctrl),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2),
    .illegal (id_illegal)
  );

  assign id_rs1 = RA_W'(id_instr[19:15]);
  assign id_rs2 = RA_W'(id_instr[24:20]);
  assign id_rd  = RA_W'(id_instr[11:7]);

  ex_ctrl_t        ex_q;
  mem_ctrl_t       mem_q;
  wb_ctrl_t        wb_q;
  logic [RA_W-1:0] ex_rd_q;
  logic [RA_W-1:0] mem_rd_q;
  logic [RA_W-1:0] wb_rd_q;

  logic taken;
  logic load_use;
  logic advance_id;

  always_comb begin
    taken    = ex_taken & ex_q.valid;
    load_use = ex_q.valid & ex_q.mem_read & (ex_rd_q != '0) &
               ((use_rs1 & (ex_rd_q == id_rs1)) | (use_rs2 & (ex_rd_q == id_rs2)));

    // Priority: external stall, then squash, then load-use. A squash wins over
    // load-use because the stalled ID instruction is about to be discarded anyway.
    stall_if   = rst_n & (stall_ext | (~taken & load_use));
    flush_if   = rst_n & ~stall_ext & taken;
    advance_id = id_valid & dec_ctrl.valid & ~taken & ~load_use;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the async reset clears every stage to a bubble, so a reset taken
    // mid-stall leaves nothing in flight when the pipe restarts.
    if (!rst_n) begin
      ex_q     <= '0;
      ex_rd_q  <= '0;
      mem_q    <= '0;
      mem_rd_q <= '0;
      wb_q     <= '0;
      wb_rd_q  <= '0;
    end else if (!stall_ext) begin
      // NOTE: non-blocking so every stage samples the previous stage's old value.
      ex_q     <= advance_id ? dec_ctrl : '0;
      ex_rd_q  <= advance_id ? id_rd : '0;
      mem_q    <= to_mem(ex_q);
      mem_rd_q <= ex_rd_q;
      wb_q     <= to_wb(mem_q);
      wb_rd_q  <= mem_rd_q;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_branch   = ex_q.branch;
  assign ex_jump     = ex_q.jump;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_asel     = ex_q.asel;
  assign ex_aluop    = ALUOP_W'(ex_q.aluop);
  assign ex_rd       = ex_rd_q;

  assign mem_valid   = mem_q.valid;
  assign mem_read    = mem_q.mem_read;
  assign mem_write   = mem_q.mem_write;
  assign mem_rd      = mem_rd_q;

  assign wb_valid    = wb_q.valid;
  assign wb_regwrite = wb_q.regwrite;
  assign wb_sel      = wb_q.wb_sel;
  assign wb_rd       = wb_rd_q;

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: decode table streamed through the pipe plus hand-written
// hazard, squash, external-stall and reset sequences, checked through a scoreboard queue.
module tb_control_pipe;

  typedef struct packed {
    logic       valid;
    logic       branch;
    logic       jump;
    logic       alusrc;
    logic       asel;
    logic [1:0] aluop;
    logic       mem_read;
    logic       mem_write;
    logic       regwrite;
    logic [1:0] wb_sel;
    logic [4:0] rd;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic        id_valid;
    logic        illegal;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        ex_taken;
  logic        stall_ext;
  logic        stall_if, flush_if;
  logic        ex_valid, ex_branch, ex_jump, ex_alusrc, ex_asel;
  logic [1:0]  ex_aluop;
  logic [4:0]  ex_rd;
  logic        mem_valid, mem_read, mem_write;
  logic [4:0]  mem_rd;
  logic        wb_valid, wb_regwrite;
  logic [1:0]  wb_sel;
  logic [4:0]  wb_rd;
  logic        id_illegal;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t q[$];
  vec_t vt[13];

  always #5 clk = ~clk;

  control_pipe #(.ALUOP_W(2), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .ex_taken(ex_taken), .stall_ext(stall_ext), .stall_if(stall_if), .flush_if(flush_if),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_alusrc(ex_alusrc),
    .ex_asel(ex_asel), .ex_aluop(ex_aluop), .ex_rd(ex_rd), .mem_valid(mem_valid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rd(mem_rd), .wb_valid(wb_valid),
    .wb_regwrite(wb_regwrite), .wb_sel(wb_sel), .wb_rd(wb_rd), .id_illegal(id_illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b0, rd, op};
  endfunction

  function automatic exp_t mk_e(input logic v, input logic b, input logic j, input logic as,
                                input logic ae, input logic [1:0] op, input logic mr,
                                input logic mw, input logic rw, input logic [1:0] ws,
                                input logic [4:0] rd);
    exp_t e;
    e.valid = v; e.branch = b; e.jump = j; e.alusrc = as; e.asel = ae; e.aluop = op;
    e.mem_read = mr; e.mem_write = mw; e.regwrite = rw; e.wb_sel = ws; e.rd = rd;
    return e;
  endfunction

  function automatic exp_t e_r(input logic [4:0] rd);
    return mk_e(1, 0, 0, 0, 0, 2'b10, 0, 0, rd != 0, 2'b00, rd);
  endfunction

  function automatic exp_t e_i(input logic [4:0] rd);
    return mk_e(1, 0, 0, 1, 0, 2'b11, 0, 0, rd != 0, 2'b00, rd);
  endfunction

  function automatic exp_t e_ld(input logic [4:0] rd);
    return mk_e(1, 0, 0, 1, 0, 2'b00, 1, 0, rd != 0, 2'b01, rd);
  endfunction

  task automatic check_stages(input string tag);
    exp_t ee, em, ew;
    ee = q[$];
    em = q[$-1];
    ew = q[$-2];
    check({tag, " ex"}, 32'({ex_valid, ex_branch, ex_jump, ex_alusrc, ex_asel, ex_aluop, ex_rd}),
          32'({ee.valid, ee.branch, ee.jump, ee.alusrc, ee.asel, ee.aluop, ee.rd}));
    check({tag, " mem"}, 32'({mem_valid, mem_read, mem_write, mem_rd}),
          32'({em.valid, em.mem_read, em.mem_write, em.rd}));
    check({tag, " wb"}, 32'({wb_valid, wb_regwrite, wb_sel, wb_rd}),
          32'({ew.valid, ew.regwrite, ew.wb_sel, ew.rd}));
  endtask

  // One clock: push what should enter EX (unless the pipe holds), then check all stages.
  task automatic step(input string tag, input exp_t e, input bit hold);
    @(posedge clk);
    #1;
    if (!hold) q.push_back(e);
    check_stages(tag);
    if (q.size() > 3) void'(q.pop_front());
  endtask

  task automatic drain(input string tag);
    id_valid = 1'b0;
    for (int k = 0; k < 3; k++) step(tag, '0, 1'b0);
  endtask

  task automatic reset_queue();
    q.delete();
    for (int k = 0; k < 3; k++) q.push_back('0);
  endtask

  initial begin
    vt[0]  = '{enc(7'b0110011, 5'd3, 5'd1, 5'd2), 1'b1, 1'b0, e_r(5'd3)};
    vt[1]  = '{enc(7'b0010011, 5'd4, 5'd1, 5'd0), 1'b1, 1'b0, e_i(5'd4)};
    vt[2]  = '{enc(7'b0000011, 5'd5, 5'd2, 5'd0), 1'b1, 1'b0, e_ld(5'd5)};
    vt[3]  = '{enc(7'b0100011, 5'd7, 5'd1, 5'd3), 1'b1, 1'b0,
               mk_e(1, 0, 0, 1, 0, 2'b00, 0, 1, 0, 2'b00, 5'd7)};
    vt[4]  = '{enc(7'b1100011, 5'd9, 5'd1, 5'd2), 1'b1, 1'b0,
               mk_e(1, 1, 0, 0, 0, 2'b01, 0, 0, 0, 2'b00, 5'd9)};
    vt[5]  = '{enc(7'b1101111, 5'd1, 5'd0, 5'd0), 1'b1, 1'b0,
               mk_e(1, 0, 1, 0, 0, 2'b00, 0, 0, 1, 2'b10, 5'd1)};
    vt[6]  = '{enc(7'b0110011, 5'd0, 5'd1, 5'd2), 1'b1, 1'b0, e_r(5'd0)};
    vt[7]  = '{enc(7'b1111111, 5'd6, 5'd1, 5'd2), 1'b1, 1'b1, '0};
`ifdef CONTROL_PIPE_EXT_OPS_EN
    vt[8]  = '{enc(7'b0110111, 5'd8, 5'd0, 5'd0), 1'b1, 1'b0,
               mk_e(1, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b11, 5'd8)};
    vt[9]  = '{enc(7'b0010111, 5'd10, 5'd0, 5'd0), 1'b1, 1'b0,
               mk_e(1, 0, 0, 1, 1, 2'b00, 0, 0, 1, 2'b00, 5'd10)};
    vt[10] = '{enc(7'b1100111, 5'd11, 5'd2, 5'd0), 1'b1, 1'b0,
               mk_e(1, 0, 1, 1, 0, 2'b00, 0, 0, 1, 2'b10, 5'd11)};
`else
    vt[8]  = '{enc(7'b0110111, 5'd8, 5'd0, 5'd0), 1'b1, 1'b1, '0};
    vt[9]  = '{enc(7'b0010111, 5'd10, 5'd0, 5'd0), 1'b1, 1'b1, '0};
    vt[10] = '{enc(7'b1100111, 5'd11, 5'd2, 5'd0), 1'b1, 1'b1, '0};
`endif
    vt[11] = '{enc(7'b0000011, 5'd0, 5'd1, 5'd0), 1'b1, 1'b0, e_ld(5'd0)};
    vt[12] = '{enc(7'b0110011, 5'd12, 5'd1, 5'd2), 1'b0, 1'b0, '0};

    rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; ex_taken = 1'b0; stall_ext = 1'b0;

    // Reset state, including stall_ext asserted while in reset.
    #12;
    stall_ext = 1'b1;
    #1;
    check("reset outputs", 32'({ex_valid, ex_branch, ex_jump, ex_alusrc, ex_asel, ex_aluop, ex_rd,
                                mem_valid, mem_read, mem_write, mem_rd,
                                wb_valid, wb_regwrite, wb_sel, wb_rd}), 32'd0);
    check("reset stall_if", 32'(stall_if), 32'd0);
    check("reset flush_if", 32'(flush_if), 32'd0);
    stall_ext = 1'b0;
    rst_n     = 1'b1;
    reset_queue();

    // Decode table streamed back to back; no load-use pairs in the sequence.
    for (int i = 0; i < 13; i++) begin
      id_instr = vt[i].instr;
      id_valid = vt[i].id_valid;
      #1;
      check($sformatf("vec%0d illegal", i), 32'(id_illegal), 32'(vt[i].illegal));
      check($sformatf("vec%0d stall_if", i), 32'(stall_if), 32'd0);
      step($sformatf("vec%0d", i), vt[i].e, 1'b0);
    end
    drain("table drain");

    // Load-use: lw x5 then add x6,x5,x1 stalls exactly one cycle.
    id_valid = 1'b1;
    id_instr = enc(7'b0000011, 5'd5, 5'd1, 5'd0);
    step("lu lw", e_ld(5'd5), 1'b0);
    id_instr = enc(7'b0110011, 5'd6, 5'd5, 5'd1);
    #1;
    check("lu stall_if", 32'(stall_if), 32'd1);
    check("lu flush_if", 32'(flush_if), 32'd0);
    step("lu bubble", '0, 1'b0);
    check("lu stall released", 32'(stall_if), 32'd0);
    step("lu add", e_r(5'd6), 1'b0);
    drain("lu drain");

    // Load to x0 never stalls and never writes back.
    id_valid = 1'b1;
    id_instr = enc(7'b0000011, 5'd0, 5'd1, 5'd0);
    step("x0 lw", e_ld(5'd0), 1'b0);
    id_instr = enc(7'b0110011, 5'd1, 5'd0, 5'd0);
    #1;
    check("x0 stall_if", 32'(stall_if), 32'd0);
    step("x0 add", e_r(5'd1), 1'b0);
    drain("x0 drain");

    // Taken branch squashes the R instruction in ID.
    id_valid = 1'b1;
    id_instr = enc(7'b1100011, 5'd9, 5'd1, 5'd2);
    step("br beq", mk_e(1, 1, 0, 0, 0, 2'b01, 0, 0, 0, 2'b00, 5'd9), 1'b0);
    id_instr = enc(7'b0110011, 5'd7, 5'd1, 5'd2);
    ex_taken = 1'b1;
    #1;
    check("br flush_if", 32'(flush_if), 32'd1);
    check("br stall_if", 32'(stall_if), 32'd0);
    id_valid = 1'b0;
    step("br squash", '0, 1'b0);
    check("br flush needs ex_valid", 32'(flush_if), 32'd0);
    ex_taken = 1'b0;
    drain("br drain");

    // External stall together with a taken branch and a load-use condition.
    id_valid = 1'b1;
    id_instr = enc(7'b0000011, 5'd5, 5'd1, 5'd0);
    step("sim lw", e_ld(5'd5), 1'b0);
    id_instr  = enc(7'b0110011, 5'd6, 5'd5, 5'd1);
    ex_taken  = 1'b1;
    stall_ext = 1'b1;
    #1;
    check("sim stall_if", 32'(stall_if), 32'd1);
    check("sim flush_if", 32'(flush_if), 32'd0);
    step("sim hold1", '0, 1'b1);
    step("sim hold2", '0, 1'b1);
    check("sim flush held off", 32'(flush_if), 32'd0);
    stall_ext = 1'b0;
    #1;
    check("sim flush after stall", 32'(flush_if), 32'd1);
    check("sim stall after stall", 32'(stall_if), 32'd0);
    step("sim squash", '0, 1'b0);
    ex_taken = 1'b0;
    #1;
    check("sim no stall after squash", 32'(stall_if), 32'd0);
    drain("sim drain");

    // Asynchronous reset mid-stream and mid-stall.
    id_valid = 1'b1;
    id_instr = enc(7'b0110011, 5'd3, 5'd1, 5'd2);
    step("rst pre1", e_r(5'd3), 1'b0);
    id_instr = enc(7'b0000011, 5'd5, 5'd1, 5'd0);
    step("rst pre2", e_ld(5'd5), 1'b0);
    id_instr  = enc(7'b0110011, 5'd6, 5'd5, 5'd1);
    stall_ext = 1'b1;
    ex_taken  = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check("rst async outputs", 32'({ex_valid, ex_branch, ex_jump, ex_alusrc, ex_asel, ex_aluop, ex_rd,
                                    mem_valid, mem_read, mem_write, mem_rd,
                                    wb_valid, wb_regwrite, wb_sel, wb_rd}), 32'd0);
    check("rst stall_if", 32'(stall_if), 32'd0);
    check("rst flush_if", 32'(flush_if), 32'd0);
    reset_queue();
    step("rst held", '0, 1'b1);
    #2;
    rst_n     = 1'b1;
    stall_ext = 1'b0;
    ex_taken  = 1'b0;
    id_instr  = enc(7'b0010011, 5'd4, 5'd1, 5'd0);
    step("rst first load", e_i(5'd4), 1'b0);
    drain("rst drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
